traceback_engine: RTL and testbench

- Consumes the 12-bit per-cycle relative-position words produced by the PE array and stores one row per ctr value in a local traceback RAM.
- On command, walks backward through the stored pointers from a given (row, lane) cell and emits one alignment operation per step over a valid/ready stream.
- Sits between the PE array output and the alignment-result formatter.

---
 rtl/traceback_engine_pkg.sv | 62 ++++++
 rtl/traceback_engine_if.sv | 34 +++
 rtl/traceback_engine_ram.sv | 31 +++
 rtl/traceback_engine.sv | 134 +++++++++++++
 tb/tb_traceback_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/traceback_engine_pkg.sv
// Shared types for the traceback engine: pointer codes, op encodings, FSM states, decode.
// Pure declarations; no timing of its own.
// No flow control; consumers own their handshakes.
package traceback_engine_pkg;

  localparam int B     = 4;
  localparam int L     = 8;
  localparam int DEPTH = 2 * L;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(B);
  localparam int CW    = 3 * B;

  // Relative-position codes written by the PE array, one per lane per row
  localparam logic [2:0] POS_STOP    = 3'b000;
  localparam logic [2:0] POS_TOP_UL  = 3'b001;
  localparam logic [2:0] POS_LEFT    = 3'b010;
  localparam logic [2:0] POS_DIAG_DL = 3'b011;
  localparam logic [2:0] POS_DIAG    = 3'b100;
  localparam logic [2:0] POS_TOP     = 3'b101;
  localparam logic [2:0] POS_LEFT_UL = 3'b110;
  localparam logic [2:0] POS_INV     = 3'b111;

  // Alignment operations emitted downstream
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_TOP  = 2'b01;
  localparam logic [1:0] OP_LEFT = 2'b10;
  localparam logic [1:0] OP_DIAG = 2'b11;

  // Two's-complement deltas, one bit wider than the row/lane indices
  localparam logic [AW:0] ROW_M1  = '1;
  localparam logic [AW:0] ROW_M2  = {{AW{1'b1}}, 1'b0};
  localparam logic [LW:0] LANE_M1 = '1;
  localparam logic [LW:0] LANE_0  = '0;
  localparam logic [LW:0] LANE_P1 = {{LW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT, S_FIN} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [AW:0] drow;
    logic [LW:0] dlane;
  } dec_t;

  // Map a pointer code to its op and the (row, lane) step back to the predecessor
  function automatic dec_t decode(input logic [2:0] code);
    dec_t d;
    d.op    = OP_NONE;
    d.drow  = '0;
    d.dlane = '0;
    case (code)
      POS_TOP_UL:  begin d.op = OP_TOP;  d.drow = ROW_M1; d.dlane = LANE_M1; end
      POS_LEFT:    begin d.op = OP_LEFT; d.drow = ROW_M1; d.dlane = LANE_0;  end
      POS_DIAG_DL: begin d.op = OP_DIAG; d.drow = ROW_M2; d.dlane = LANE_M1; end
      POS_DIAG:    begin d.op = OP_DIAG; d.drow = ROW_M2; d.dlane = LANE_0;  end
      POS_TOP:     begin d.op = OP_TOP;  d.drow = ROW_M1; d.dlane = LANE_0;  end
      POS_LEFT_UL: begin d.op = OP_LEFT; d.drow = ROW_M1; d.dlane = LANE_P1; end
      default:     ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/traceback_engine_if.sv
// Row-write, walk-command and op-stream signals of the traceback engine.
// Wires only; no latency.
// Op stream uses op_valid/op_ready; writes and starts are fire-and-forget.
interface traceback_engine_if;
  import traceback_engine_pkg::*;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          start;
  logic [AW-1:0] start_row;
  logic [LW-1:0] start_lane;
  logic          busy;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op;
  logic [AW-1:0] op_row;
  logic [LW-1:0] op_lane;
  logic          done;
  logic          err;

  // Producer/consumer side: writes rows, starts walks, accepts ops
  modport master (
    output wr_en, wr_addr, wr_data, start, start_row, start_lane, op_ready,
    input  busy, op_valid, op, op_row, op_lane, done, err
  );

  // Engine side
  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_row, start_lane, op_ready,
    output busy, op_valid, op, op_row, op_lane, done, err
  );

endinterface

// File: rtl/traceback_engine_ram.sv
// Traceback pointer store: DEPTH rows of 3*B bits, one write port, one sync read port.
// Read data appears one cycle after i_rd_en; same-address write is forwarded (write-first).
// No backpressure; read data holds while i_rd_en is low.
module traceback_engine_ram
  import traceback_engine_pkg::*;
(
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [CW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [CW-1:0] o_rd_data
);

  logic [CW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_rd_data;

  // Write port and registered read with write-first forwarding; contents survive reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/traceback_engine.sv
// Stores PE-array pointer rows and walks them backward from (row, lane), emitting one op per step.
// start -> first op_valid 2 cycles; handshake -> next op_valid 2 cycles; stop/invalid/range end -> done 1 cycle.
// op_valid holds op/op_row/op_lane stable until op_ready; writes and starts are dropped while busy.
module traceback_engine
  import traceback_engine_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  traceback_engine_if.slave  eng_if
);

  state_t        r_state;
  logic [AW-1:0] r_cur_row;
  logic [LW-1:0] r_cur_lane;
  logic [AW:0]   r_step;
  logic          r_busy;
  logic          r_op_valid;
  logic [1:0]    r_op;
  logic          r_done;
  logic          r_err;

  logic [CW-1:0] w_rd_data;
  logic [2:0]    w_code;
  dec_t          w_dec;
  logic [AW:0]   w_nrow;
  logic [LW:0]   w_nlane;
  logic [AW:0]   w_nstep;
  logic          w_hs;
  logic          w_walk_err;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;

  // The read data register holds between reads, so the current cell's code
  // stays decodable through the whole EMIT stall.
  assign w_code  = w_rd_data[3*r_cur_lane +: 3];
  assign w_dec   = decode(w_code);

  // Signed next-cell arithmetic; with B a power of two the sign bit alone
  // flags a lane outside [0, B-1] (lane B wraps to a negative value).
  assign w_nrow  = $signed({1'b0, r_cur_row}) + $signed(w_dec.drow);
  assign w_nlane = $signed({1'b0, r_cur_lane}) + $signed(w_dec.dlane);
  assign w_nstep = r_step + 1'b1;

  assign w_hs       = r_op_valid & eng_if.op_ready;
  assign w_walk_err = w_nrow[AW] | w_nlane[LW] | (w_nstep == (AW+1)'(DEPTH));

  // Reads are launched on the cycle that enters READ so the code is ready there
  assign w_wr_en   = eng_if.wr_en & (r_state == S_IDLE);
  assign w_rd_en   = ((r_state == S_IDLE) & eng_if.start) | (w_hs & ~w_walk_err);
  assign w_rd_addr = (r_state == S_IDLE) ? eng_if.start_row : w_nrow[AW-1:0];

  traceback_engine_ram u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (eng_if.wr_addr),
    .i_wr_data (eng_if.wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Walk controller with registered outputs; reset aborts a walk without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cur_row  <= '0;
      r_cur_lane <= '0;
      r_step     <= '0;
      r_busy     <= 1'b0;
      r_op_valid <= 1'b0;
      r_op       <= OP_NONE;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (eng_if.start) begin
            r_cur_row  <= eng_if.start_row;
            r_cur_lane <= eng_if.start_lane;
            r_step     <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          if (w_code == POS_STOP || w_code == POS_INV) begin
            r_err   <= (w_code == POS_INV);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_op       <= w_dec.op;
            r_op_valid <= 1'b1;
            r_state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            r_op_valid <= 1'b0;
            r_step     <= w_nstep;
            if (w_walk_err) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_cur_row  <= w_nrow[AW-1:0];
              r_cur_lane <= w_nlane[LW-1:0];
              r_state    <= S_READ;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign eng_if.busy     = r_busy;
  assign eng_if.op_valid = r_op_valid;
  assign eng_if.op       = r_op;
  assign eng_if.op_row   = r_cur_row;
  assign eng_if.op_lane  = r_cur_lane;
  assign eng_if.done     = r_done;
  assign eng_if.err      = r_err;

endmodule

// File: tb/tb_traceback_engine.sv
// Directed bench for traceback_engine with a queue scoreboard and an independent monitor.
// Stimulus changes 1 time unit after the rising edge; the monitor samples on the falling edge.
// Backpressure is exercised by holding op_ready low across several op_valid cycles.
module tb_traceback_engine;
  import traceback_engine_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   hs_count;

  logic [7:0] exp_q[$];
  logic       done_q[$];

  traceback_engine_if bus ();

  traceback_engine dut (
    .clk    (clk),
    .reset  (reset),
    .eng_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk(input int lane, input logic [2:0] code);
    logic [CW-1:0] d;
    d = '0;
    d[3*lane +: 3] = code;
    return d;
  endfunction

  task automatic write_row(input logic [AW-1:0] addr, input logic [CW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_walk(input logic [AW-1:0] row, input logic [LW-1:0] lane);
    bus.start      = 1'b1;
    bus.start_row  = row;
    bus.start_lane = lane;
    tick(1);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      tick(1);
      n++;
    end
    chk(name, bus.done, 1);
    tick(1);
  endtask

  task automatic push_normal();
    exp_q.push_back({OP_DIAG, 4'd5, 2'd2});
    exp_q.push_back({OP_LEFT, 4'd3, 2'd1});
    done_q.push_back(1'b0);
  endtask

  // Monitor: every accepted op and every done pulse is checked against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.op_valid && bus.op_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_op: got %0h@(%0d,%0d) expected none", bus.op, bus.op_row, bus.op_lane);
        end else begin
          chk("op_row_lane", {bus.op, bus.op_row, bus.op_lane}, exp_q.pop_front());
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got err=%0d expected no done", bus.err);
        end else begin
          chk("done_err", bus.err, done_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int h0;
    tests = 0; fails = 0; hs_count = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.start_row = '0; bus.start_lane = '0;
    bus.op_ready = 1'b1;
    tick(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_op", bus.op, 0);
    chk("rst_op_row", bus.op_row, 0);
    chk("rst_op_lane", bus.op_lane, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b0;
    tick(1);
    chk("rel_busy", bus.busy, 0);

    write_row(4'd5, mk(2, 3'b011));
    write_row(4'd3, mk(1, 3'b010));
    write_row(4'd2, mk(1, 3'b000));
    write_row(4'd1, mk(0, 3'b001));
    write_row(4'd0, mk(3, 3'b010));
    write_row(4'd7, mk(0, 3'b111));
    write_row(4'd8, mk(1, 3'b000));

    // Normal walk: (5,2) diag -> (3,1) left -> (2,1) stop
    push_normal();
    h0 = hs_count;
    start_walk(4'd5, 2'd2);
    chk("norm_busy", bus.busy, 1);
    chk("norm_lat1_valid", bus.op_valid, 0);
    tick(1);
    chk("norm_lat2_valid", bus.op_valid, 1);
    wait_done("norm_done_seen");
    chk("norm_handshakes", hs_count - h0, 2);
    chk("norm_busy_end", bus.busy, 0);

    // Backpressure on the first op for 5 cycles
    bus.op_ready = 1'b0;
    push_normal();
    start_walk(4'd5, 2'd2);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {bus.op_valid, bus.op, bus.op_row, bus.op_lane}, {1'b1, OP_DIAG, 4'd5, 2'd2});
      tick(1);
    end
    bus.op_ready = 1'b1;
    tick(1);
    chk("bp_gap_valid", bus.op_valid, 0);
    tick(1);
    chk("bp_next", {bus.op_valid, bus.op, bus.op_row, bus.op_lane}, {1'b1, OP_LEFT, 4'd3, 2'd1});
    wait_done("bp_done_seen");

    // Lane underflow: (1,0) top -> lane -1
    exp_q.push_back({OP_TOP, 4'd1, 2'd0});
    done_q.push_back(1'b1);
    start_walk(4'd1, 2'd0);
    tick(1);
    chk("rng1_valid", bus.op_valid, 1);
    tick(1);
    chk("rng1_done_lat", bus.done, 1);
    wait_done("rng1_done_seen");
    chk("rng1_err_sticky", bus.err, 1);

    // Row underflow: (0,3) left -> row -1
    exp_q.push_back({OP_LEFT, 4'd0, 2'd3});
    done_q.push_back(1'b1);
    start_walk(4'd0, 2'd3);
    chk("rng2_err_cleared", bus.err, 0);
    wait_done("rng2_done_seen");
    chk("rng2_err", bus.err, 1);

    // Invalid and stop codes at entry: no ops
    h0 = hs_count;
    done_q.push_back(1'b1);
    start_walk(4'd7, 2'd0);
    chk("inv_lat1_done", bus.done, 0);
    tick(1);
    chk("inv_lat2_done", bus.done, 1);
    chk("inv_err", bus.err, 1);
    chk("inv_no_valid", bus.op_valid, 0);
    wait_done("inv_done_seen");
    done_q.push_back(1'b0);
    start_walk(4'd8, 2'd1);
    wait_done("stop_done_seen");
    chk("stop_err", bus.err, 0);
    chk("entry_no_handshakes", hs_count - h0, 0);

    // Write and start while busy are ignored
    push_normal();
    h0 = hs_count;
    start_walk(4'd5, 2'd2);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = mk(1, 3'b111);
    bus.start = 1'b1; bus.start_row = 4'd7; bus.start_lane = 2'd0;
    tick(1);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    wait_done("busy_done_seen");
    chk("busy_handshakes", hs_count - h0, 2);
    chk("busy_err", bus.err, 0);
    done_q.push_back(1'b0);
    start_walk(4'd2, 2'd1);
    wait_done("busy_row2_done_seen");
    chk("busy_row2_kept", bus.err, 0);

    // Reset mid-walk while stalled on the first op
    bus.op_ready = 1'b0;
    exp_q.push_back({OP_DIAG, 4'd5, 2'd2});
    start_walk(4'd5, 2'd2);
    tick(1);
    chk("mid_valid", bus.op_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.op_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    exp_q.delete();
    done_q.delete();
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("mid_rel_busy", bus.busy, 0);
    chk("mid_rel_done", bus.done, 0);
    bus.op_ready = 1'b1;
    push_normal();
    h0 = hs_count;
    start_walk(4'd5, 2'd2);
    wait_done("post_rst_done_seen");
    chk("post_rst_handshakes", hs_count - h0, 2);
    chk("post_rst_err", bus.err, 0);

    tick(2);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
